// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 8;
  localparam int unsigned PRESCALE_WIDTH_DEF = 5;

  // Sample points relative to the bit centre (P/2).
  localparam int SAMPLE_OFS_EARLY = -1;
  localparam int SAMPLE_OFS_MID   = 0;
  localparam int SAMPLE_OFS_LATE  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // 2-of-3 vote used to reject single-sample noise on the line.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Bit timing for the receiver: edge counter within a serial bit and the
// three-sample majority voter around the bit centre.
module uart_rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_enable,
  input  logic                      i_rx,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_c,
  output logic                      o_sample_done_c,
  output logic                      o_bit_done_c
);

  localparam int unsigned PW = PRESCALE_WIDTH;

  logic [PW-1:0] r_edge_cnt;
  logic          r_samp_early;
  logic          r_samp_mid;
  logic [PW-1:0] w_half;
  logic [PW-1:0] w_pt_early;
  logic [PW-1:0] w_pt_mid;
  logic [PW-1:0] w_pt_late;
  logic [PW-1:0] w_last;

  assign w_half     = i_prescale >> 1;
  assign w_pt_early = w_half + PW'(SAMPLE_OFS_EARLY);
  assign w_pt_mid   = w_half + PW'(SAMPLE_OFS_MID);
  assign w_pt_late  = w_half + PW'(SAMPLE_OFS_LATE);
  assign w_last     = i_prescale - PW'(1);

  // Edge counter: start detection is sample 0, so it loads 1; wraps at P-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge_cnt <= '0;
    end else if (i_start) begin
      r_edge_cnt <= PW'(1);
    end else if (i_enable) begin
      r_edge_cnt <= (r_edge_cnt == w_last) ? '0 : r_edge_cnt + PW'(1);
    end else begin
      r_edge_cnt <= '0;
    end
  end

  // Capture the first two samples; the third is taken live at the vote.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_samp_early <= 1'b0;
      r_samp_mid   <= 1'b0;
    end else if (i_enable) begin
      if (r_edge_cnt == w_pt_early) r_samp_early <= i_rx;
      if (r_edge_cnt == w_pt_mid)   r_samp_mid   <= i_rx;
    end
  end

  assign o_bit_c         = majority3(r_samp_early, r_samp_mid, i_rx);
  assign o_sample_done_c = i_enable && (r_edge_cnt == w_pt_late);
  assign o_bit_done_c    = i_enable && (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx_top.sv
// Oversampling UART receiver: start/data/parity/stop framing, delivers good
// bytes on P_DATA with a one-cycle Data_valid strobe.
// Optional: define UART_RX_ERR_FLAGS_EN to add Par_err/Stp_err pulse outputs.
module uart_rx_top
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_valid
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic                      Par_err,
  output logic                      Stp_err
`endif
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e                 r_state;
  rx_state_e                 w_next_state;
  logic                      w_start_det;
  logic                      w_frame_end;

  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [BIT_CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_err;
  logic                      r_stp_err;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_data_valid;

  logic                      w_bit;
  logic                      w_sample_done;
  logic                      w_bit_done;

  uart_rx_data_sampling #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampling (
    .i_clk           (CLK),
    .i_rst           (RST),
    .i_start         (w_start_det),
    .i_enable        (r_state != ST_IDLE),
    .i_rx            (RX_IN),
    .i_prescale      (r_prescale),
    .o_bit_c         (w_bit),
    .o_sample_done_c (w_sample_done),
    .o_bit_done_c    (w_bit_done)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic plus frame start/end strobes.
  always_comb begin
    w_next_state = r_state;
    w_start_det  = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!RX_IN) begin
          w_start_det  = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        if (w_sample_done && w_bit) w_next_state = ST_IDLE;
        else if (w_bit_done)        w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_done && (r_bit_cnt == LAST_BIT))
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_bit_done) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_done) begin
          w_frame_end  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame config latch, bit counter, shift register and error flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      if (w_start_det) begin
        r_prescale <= Prescale;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_bit_cnt  <= '0;
        r_par_err  <= 1'b0;
        r_stp_err  <= 1'b0;
      end
      if (r_state == ST_DATA) begin
        if (w_sample_done) r_shift[r_bit_cnt] <= w_bit;
        if (w_bit_done)
          r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_CNT_W'(1);
      end
      if ((r_state == ST_PARITY) && w_sample_done && (w_bit != ((^r_shift) ^ r_par_typ)))
        r_par_err <= 1'b1;
      if ((r_state == ST_STOP) && w_sample_done && !w_bit)
        r_stp_err <= 1'b1;
    end
  end

  // Publish the byte only for a frame with no parity or stop error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_frame_end && !r_par_err && !r_stp_err) begin
        r_p_data     <= r_shift;
        r_data_valid <= 1'b1;
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign Data_valid = r_data_valid;

`ifdef UART_RX_ERR_FLAGS_EN
  logic r_par_err_pulse;
  logic r_stp_err_pulse;

  // Error pulses land where Data_valid would have for a rejected frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_err_pulse <= 1'b0;
      r_stp_err_pulse <= 1'b0;
    end else begin
      r_par_err_pulse <= w_frame_end && r_par_err;
      r_stp_err_pulse <= w_frame_end && r_stp_err;
    end
  end

  assign Par_err = r_par_err_pulse;
  assign Stp_err = r_stp_err_pulse;
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top with a scoreboard of expected bytes.
module tb_uart_rx_top;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [4:0] Prescale = 5'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       Par_err;
  logic       Stp_err;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         valid_cnt = 0;
  int         par_cnt = 0;
  int         stp_cnt = 0;
  int         t_start = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  int         pulse_cyc[$];

  uart_rx_top dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .Par_err    (Par_err),
    .Stp_err    (Stp_err)
`endif
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor: pops the scoreboard on every Data_valid pulse.
  always @(negedge CLK) begin
    if (Data_valid === 1'b1) begin
      valid_cnt++;
      pulse_cyc.push_back(cyc);
      check("valid_width", 32'(prev_valid), 32'd0);
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("p_data", 32'(P_DATA), 32'(exp_q.pop_front()));
    end
    prev_valid = Data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
    if (Par_err === 1'b1) par_cnt++;
    if (Stp_err === 1'b1) stp_cnt++;
`endif
  end

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic sb, input int p);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pe) send_bit(pb, p);
    send_bit(sb, p);
    RX_IN = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d, input logic pe, input logic pt, input int p);
    exp_q.push_back(d);
    send_frame(d, pe, (^d) ^ pt, 1'b1, p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset takes effect without a clock edge.
    #1 RST = 1'b1;
    #4;
    check("rst_p_data", 32'(P_DATA), 32'h0);
    check("rst_valid", 32'(Data_valid), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(4);

    // Back-to-back even-parity frames.
    PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 5'd8;
    send_good(8'h55, 1'b1, 1'b0, 8);
    send_good(8'h7D, 1'b1, 1'b0, 8);
    settle(2);
    check("b2b_count", 32'(valid_cnt), 32'd2);
    check("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd88);
    check("b2b_last", 32'(P_DATA), 32'h7D);

    // Odd parity: good then bad parity bit.
    idle(3);
    PAR_TYP = 1'b1;
    send_good(8'hA3, 1'b1, 1'b1, 8);
    idle(4);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 8);
    idle(4);
    settle(1);
    check("odd_count", 32'(valid_cnt), 32'd3);
    check("odd_hold", 32'(P_DATA), 32'hA3);
`ifdef UART_RX_ERR_FLAGS_EN
    check("par_err_pulse", 32'(par_cnt), 32'd1);
    check("par_err_no_stp", 32'(stp_cnt), 32'd0);
`endif

    // No parity, P=16: frame is 10 bits of 16 clocks.
    idle(3);
    PAR_EN = 1'b0; Prescale = 5'd16;
    t_start = cyc;
    send_good(8'h0F, 1'b0, 1'b0, 16);
    idle(4);
    settle(1);
    check("p16_count", 32'(valid_cnt), 32'd4);
    check("p16_latency", 32'(pulse_cyc[3] - t_start), 32'd160);

    // Stop error, then a good frame.
    idle(3);
    Prescale = 5'd8;
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 8);
    idle(16);
    settle(1);
    check("stp_count", 32'(valid_cnt), 32'd4);
    check("stp_hold", 32'(P_DATA), 32'h0F);
`ifdef UART_RX_ERR_FLAGS_EN
    check("stp_err_pulse", 32'(stp_cnt), 32'd1);
`endif
    idle(3);
    send_good(8'h12, 1'b0, 1'b0, 8);
    idle(4);
    settle(1);
    check("after_stp", 32'(P_DATA), 32'h12);

    // Start glitch of two clocks, then a good frame.
    idle(3);
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(20);
    settle(1);
    check("glitch_count", 32'(valid_cnt), 32'd5);
    idle(3);
    send_good(8'h81, 1'b0, 1'b0, 8);
    idle(4);
    settle(1);
    check("after_glitch", 32'(P_DATA), 32'h81);

    // Reset mid-frame aborts it; next frame still works.
    idle(3);
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    idle(16);
    send_good(8'h3C, 1'b0, 1'b0, 8);
    idle(4);
    settle(1);
    check("after_rst", 32'(P_DATA), 32'h3C);
    check("total_valid", 32'(valid_cnt), 32'd7);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef UART_RX_ERR_FLAGS_EN
    check("par_err_total", 32'(par_cnt), 32'd1);
    check("stp_err_total", 32'(stp_cnt), 32'd1);
`endif

    // Asynchronous reset away from any clock edge.
    RST = 1'b1;
    #2;
    check("async_rst_p_data", 32'(P_DATA), 32'h0);
    check("async_rst_valid", 32'(Data_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
